// File: rtl/uart_tx_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter.
package uart_tx_pkg;

    // Transmitter FSM state encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Parity type selector values.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_calc.sv
// Combinational parity generator: even -> XOR-reduce, odd -> XNOR-reduce.
module parity_calc
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  typ_i,
    output logic                  par_o
);

    // Select between even and odd parity of the word.
    always_comb begin
        par_o = ^data_i;
        if (typ_i == PAR_ODD) begin
            par_o = ~(^data_i);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a first-word-fall-through FIFO, one bit per CLK.
module fifo_uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EMPTY,
    input  logic [DATA_WIDTH-1:0] RD_DATA,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  R_INC,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    tx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  r_inc_q, r_inc_d;
    logic                  load_c;
    logic                  par_c;

    // Parity of the FIFO head word, captured only on a load edge.
    parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_calc (
        .data_i (RD_DATA),
        .typ_i  (PAR_TYP),
        .par_o  (par_c)
    );

    // State and output registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            r_inc_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            r_inc_q   <= r_inc_d;
        end
    end

    // Next-state logic; tx_d is the line value for the cycle after the edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        r_inc_d   = 1'b0;
        load_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!EMPTY) begin
                    load_c = 1'b1;
                end
            end
            ST_START: begin
                tx_d    = shreg_q[0];
                shreg_d = shreg_q >> 1;
                cnt_d   = '0;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (par_en_q) begin
                        tx_d    = par_bit_q;
                        state_d = ST_PARITY;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                end
            end
            ST_PARITY: begin
                tx_d    = 1'b1;
                state_d = ST_STOP;
            end
            ST_STOP: begin
                if (!EMPTY) begin
                    load_c = 1'b1;
                end else begin
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // Load: capture word and config, pop the FIFO, start bit goes out now.
        if (load_c) begin
            shreg_d   = RD_DATA;
            par_en_d  = PAR_EN;
            par_bit_d = par_c;
            cnt_d     = '0;
            tx_d      = 1'b0;
            busy_d    = 1'b1;
            r_inc_d   = 1'b1;
            state_d   = ST_START;
        end
    end

    assign TX_OUT = tx_q;
    assign BUSY   = busy_q;
    assign R_INC  = r_inc_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a FIFO model and an expected-bit scoreboard.
module tb_fifo_uart_tx;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       EMPTY = 1'b1;
    logic [7:0] RD_DATA = 8'h00;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       R_INC;
    logic       TX_OUT;
    logic       BUSY;

    logic [7:0] fifo_q[$];
    logic       exp_q[$];
    int         rinc_cyc[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         rinc_cnt = 0;

    fifo_uart_tx #(.DATA_WIDTH(8)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .EMPTY   (EMPTY),
        .RD_DATA (RD_DATA),
        .PAR_EN  (PAR_EN),
        .PAR_TYP (PAR_TYP),
        .R_INC   (R_INC),
        .TX_OUT  (TX_OUT),
        .BUSY    (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic update_fifo_if();
        EMPTY   = (fifo_q.size() == 0);
        RD_DATA = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    // Advance to the next falling edge; service the FIFO pop strobe there.
    task automatic tick();
        logic [7:0] tmp;
        @(negedge CLK);
        cyc++;
        if (RST && R_INC) begin
            if (fifo_q.size() != 0) tmp = fifo_q.pop_front();
            rinc_cnt++;
            rinc_cyc.push_back(cyc);
        end
        update_fifo_if();
    endtask

    // Enqueue a word and the frame it must produce under the given load-time config.
    task automatic push_word(input logic [7:0] d, input logic pe, input logic pt);
        fifo_q.push_back(d);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (pe) exp_q.push_back(pt ? ~(^d) : ^d);
        exp_q.push_back(1'b1);
        update_fifo_if();
    endtask

    task automatic wait_busy(input string tag);
        int w = 0;
        while (BUSY !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        chk({tag, "_busy_rise"}, BUSY, 1'b1);
    endtask

    // Compare every queued line bit cycle by cycle; optionally raise PAR_EN mid-frame.
    task automatic check_stream(input string tag, input int toggle_idx);
        int idx = 0;
        logic b;
        wait_busy(tag);
        while (exp_q.size() != 0) begin
            b = exp_q.pop_front();
            chk($sformatf("%s_bit%0d", tag, idx), TX_OUT, b);
            chk($sformatf("%s_busy%0d", tag, idx), BUSY, 1'b1);
            if (idx == toggle_idx) PAR_EN = 1'b1;
            idx++;
            tick();
        end
        chk({tag, "_busy_fall"}, BUSY, 1'b0);
        chk({tag, "_idle_line"}, TX_OUT, 1'b1);
    endtask

    initial begin
        int r0;
        int n;
        logic b;

        // Reset values while RST is held.
        tick();
        chk("rst_tx", TX_OUT, 1'b1);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_rinc", R_INC, 1'b0);
        RST = 1'b1;

        // Empty FIFO: line stays idle.
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("idle_tx", TX_OUT, 1'b1);
            chk("idle_busy", BUSY, 1'b0);
            chk("idle_rinc", R_INC, 1'b0);
        end

        // 0xA5, no parity: 10-cycle frame, one pop.
        r0 = rinc_cnt;
        PAR_EN = 1'b0;
        push_word(8'hA5, 1'b0, 1'b0);
        check_stream("a5", -1);
        chk("a5_rinc", 32'(rinc_cnt - r0), 1);

        // 0x03 with even then odd parity.
        PAR_EN = 1'b1; PAR_TYP = 1'b0;
        push_word(8'h03, 1'b1, 1'b0);
        check_stream("p_even", -1);
        PAR_TYP = 1'b1;
        push_word(8'h03, 1'b1, 1'b1);
        check_stream("p_odd", -1);

        // Three back-to-back frames.
        PAR_EN = 1'b0; PAR_TYP = 1'b0;
        r0 = rinc_cnt;
        rinc_cyc.delete();
        push_word(8'h01, 1'b0, 1'b0);
        push_word(8'h02, 1'b0, 1'b0);
        push_word(8'h03, 1'b0, 1'b0);
        check_stream("b2b", -1);
        chk("b2b_rinc", 32'(rinc_cnt - r0), 3);
        n = rinc_cyc.size();
        if (n >= 3) begin
            chk("b2b_gap1", 32'(rinc_cyc[1] - rinc_cyc[0]), 10);
            chk("b2b_gap2", 32'(rinc_cyc[2] - rinc_cyc[1]), 10);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("b2b_after_busy", BUSY, 1'b0);
            chk("b2b_after_rinc", R_INC, 1'b0);
        end

        // PAR_EN raised during data of 0x55: only the following frame carries parity.
        PAR_EN = 1'b0; PAR_TYP = 1'b1;
        push_word(8'h55, 1'b0, 1'b1);
        push_word(8'h0F, 1'b1, 1'b1);
        check_stream("toggle", 3);

        // Reset during data bit 3, then a clean restart.
        PAR_EN = 1'b0; PAR_TYP = 1'b0;
        push_word(8'h3C, 1'b0, 1'b0);
        wait_busy("rstmid");
        for (int idx = 0; idx <= 4; idx++) begin
            b = exp_q.pop_front();
            chk($sformatf("rstmid_bit%0d", idx), TX_OUT, b);
            if (idx < 4) tick();
        end
        RST = 1'b0;
        #1;
        chk("rstmid_tx", TX_OUT, 1'b1);
        chk("rstmid_busy", BUSY, 1'b0);
        chk("rstmid_rinc", R_INC, 1'b0);
        exp_q.delete();
        tick();
        push_word(8'h96, 1'b0, 1'b0);
        RST = 1'b1;
        check_stream("restart", -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

- UART transmitter that drains the read side of the asynchronous FIFO and sits directly downstream of it in the TX clock domain.
- Whenever the FIFO reports data (`EMPTY`=0), it captures `RD_DATA`, issues a one-cycle `R_INC` to pop the word, and serialises a frame on `TX_OUT`: start bit, data LSB-first, optional parity bit, stop bit.
- One bit is sent per `CLK` cycle; `CLK` is the baud-rate clock.

## Interface
Parameters:
- `DATA_WIDTH`, 8, payload width; must match the FIFO `DATA_WIDTH`.

Ports:
- `CLK`  in  1  TX/baud clock; same clock as the FIFO `R_CLK`.
- `RST`  in  1  asynchronous reset, active-low.
- `EMPTY`  in  1  FIFO empty flag.
- `RD_DATA`  in  `DATA_WIDTH`  FIFO head word; valid whenever `EMPTY`=0 (first-word fall-through).
- `PAR_EN`  in  1  1 = append parity bit.
- `PAR_TYP`  in  1  0 = even parity, 1 = odd parity.
- `R_INC`  out  1  FIFO pop strobe; registered, one cycle wide.
- `TX_OUT`  out  1  serial line; registered, idles high.
- `BUSY`  out  1  high while a frame is on the line; registered.

## Operation
- Reset values: `TX_OUT`=1, `BUSY`=0, `R_INC`=0, state IDLE, bit counter 0, shift register 0.
- FSM states:
  - IDLE: if `EMPTY`=0 at the rising edge, perform a load and go to START. Otherwise stay in IDLE.
  - START: `TX_OUT`=0 for one cycle, then go to DATA.
  - DATA: shifts out `DATA_WIDTH` bits, LSB first, counting 0..`DATA_WIDTH`-1. On the last bit, go to PARITY if the latched `PAR_EN`=1, else go to STOP.
  - PARITY: drives the parity bit for one cycle, then goes to STOP.
  - STOP: `TX_OUT`=1 for one cycle. At the closing edge, if `EMPTY`=0, perform a load and go to START (back-to-back, no idle gap). Otherwise go to IDLE.
- Load edge, all in one clock edge:
  - capture `RD_DATA` into the shift register;
  - latch `PAR_EN` and `PAR_TYP`;
  - set `R_INC`=1 for the following cycle only;
  - compute parity from the captured data.
- Configuration changes on `PAR_EN`/`PAR_TYP` mid-frame have no effect until the next load.
- Parity arithmetic:
  - even: bit = XOR-reduce(data);
  - odd: bit = XNOR-reduce(data).
- Frame length is `DATA_WIDTH`+2 cycles, or `DATA_WIDTH`+3 with parity: 10 or 11 cycles at default width.
- `BUSY`=1 from the load edge through the end of the stop bit. It stays 1 continuously across back-to-back frames and drops to 0 at the edge that enters IDLE.
- Reset mid-frame: all outputs return to their reset values immediately (asynchronous). The in-flight word is lost; it was already popped from the FIFO.

## Timing
- Load at edge k:
  - `R_INC`=1 during cycle k..k+1; the FIFO pops at edge k+1.
  - `TX_OUT`=0 (start bit) from k to k+1.
  - data bit i from k+1+i to k+2+i.
  - parity bit (if enabled) from k+1+`DATA_WIDTH`.
  - stop bit in the last cycle of the frame.
- Latency from `EMPTY` falling (sampled at an edge in IDLE) to the start bit on `TX_OUT` is 0 cycles after that edge; the bit appears at edge k.
- `EMPTY` is sampled only in IDLE, or at the closing edge of STOP. The FIFO's `EMPTY` update after the pop (edge k+1 plus synchroniser delay) has ≥9 cycles of slack before the next sample.
- `R_INC` is never asserted while `EMPTY`=1 at the load edge. It is never asserted twice per word.

## Structure
- Shared package `uart_tx_pkg` holds:
  - state encoding constants (IDLE, START, DATA, PARITY, STOP; 3 bits);
  - `PAR_EVEN`=0 and `PAR_ODD`=1.
- One sub-module, `parity_calc`: combinational, `DATA_WIDTH`-parameterised, inputs data and type, output one bit.
- The top level contains the FSM, the bit counter (width `$clog2(DATA_WIDTH)`), the shift register and the output registers.

## Test plan
- Reset, then hold `EMPTY`=1 for 50 cycles -> `TX_OUT`=1, `BUSY`=0 and `R_INC`=0 throughout.
- `RD_DATA`=0xA5, `PAR_EN`=0, `EMPTY` falls -> one `R_INC` pulse; `TX_OUT` sequence 0,1,0,1,0,0,1,0,1,1 (10 cycles); `BUSY` high for exactly 10 cycles.
- 0x03 with `PAR_EN`=1, `PAR_TYP`=0 -> parity bit 0, 11-cycle frame. Repeat with `PAR_TYP`=1 -> parity bit 1.
- FIFO model preloaded with 0x01, 0x02, 0x03, `PAR_EN`=0 -> three frames with no gap, 30 cycles. `BUSY` is continuously 1. Exactly three `R_INC` pulses, 10 cycles apart. Idle afterwards.
- Toggle `PAR_EN` 0->1 during the data bits of frame 0x55 -> that frame has no parity bit; the next frame carries parity.
- Assert `RST` during data bit 3 -> `TX_OUT`=1 and `BUSY`=0 immediately. After release with `EMPTY`=0, a fresh frame starts cleanly from the start bit.
